// File: rtl/imem_boot_loader.sv
// Loads a framed byte-stream image into instruction memory through the chip's IWEN/I_Addr/wInst port.
// Frame: SYNC, LEN (words-1), 4*(LEN+1) data bytes (MSB first per word), XOR checksum.
module imem_boot_loader #(
    parameter int         ADDR_W  = 7,
    parameter logic [7:0] SYNC    = 8'hA5,
    parameter int         TIMEOUT = 50000,
    parameter int         HOLD    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              IWEN,
    output logic [ADDR_W-1:0] I_Addr,
    output logic [31:0]       wInst,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);

    localparam int IDX_W  = ADDR_W + 1;
    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    localparam int HOLD_W = $clog2(HOLD + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_HOLD,
        S_DONE
    } state_t;

    state_t              r_state;
    logic                r_rx_ready;
    logic                r_iwen;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_winst;
    logic                r_busy;
    logic                r_done;
    logic [1:0]          r_err;
    logic [1:0]          r_bcnt;
    logic [IDX_W-1:0]    r_widx;
    logic [ADDR_W-1:0]   r_last;
    logic [TMR_W-1:0]    r_tmr;
    logic [HOLD_W-1:0]   r_hold;
    logic [23:0]         r_asm;
    logic [7:0]          r_csum;

    logic                w_xfer;
    logic                w_in_frame;
    logic [7:0]          w_len_hi;
    logic                w_len_bad;
    logic                w_tmo;
    logic                w_abort;
    logic                w_last_word;

    assign w_xfer      = rx_valid & r_rx_ready;
    assign w_in_frame  = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_len_hi    = rx_data >> ADDR_W;
    assign w_len_bad   = (w_len_hi != 8'd0);
    assign w_tmo       = w_in_frame && !w_xfer && (r_tmr == TMR_W'(TIMEOUT - 1));
    assign w_abort     = w_tmo || ((r_state == S_LEN) && w_xfer && w_len_bad);
    // Index is one bit wider than the address so a full 2^ADDR_W image never wraps.
    assign w_last_word = (r_widx == {1'b0, r_last});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rx_ready <= 1'b0;
            r_iwen     <= 1'b0;
            r_addr     <= '0;
            r_winst    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 2'b00;
            r_bcnt     <= '0;
            r_widx     <= '0;
            r_last     <= '0;
            r_tmr      <= '0;
            r_hold     <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_state    <= S_IDLE;
                r_rx_ready <= 1'b0;
                r_iwen     <= 1'b0;
                r_busy     <= 1'b0;
                r_err      <= w_tmo ? 2'b10 : 2'b11;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_rx_ready <= 1'b1;
                        if (w_xfer && (rx_data == SYNC)) begin
                            r_state <= S_LEN;
                            r_iwen  <= 1'b1;
                            r_busy  <= 1'b1;
                            r_err   <= 2'b00;
                            r_addr  <= '0;
                            r_winst <= '0;
                            r_tmr   <= '0;
                        end
                    end
                    S_LEN: begin
                        if (w_xfer) begin
                            r_tmr   <= '0;
                            r_last  <= rx_data[ADDR_W-1:0];
                            r_widx  <= '0;
                            r_bcnt  <= '0;
                            r_state <= S_DATA;
                        end else begin
                            r_tmr <= r_tmr + TMR_W'(1);
                        end
                    end
                    S_DATA: begin
                        if (w_xfer) begin
                            r_tmr  <= '0;
                            r_bcnt <= r_bcnt + 2'd1;
                            // Address and data move together only on a complete word.
                            if (r_bcnt == 2'd3) begin
                                r_winst <= {r_asm, rx_data};
                                r_addr  <= r_widx[ADDR_W-1:0];
                                r_widx  <= r_widx + IDX_W'(1);
                                if (w_last_word) begin
                                    r_state <= S_CSUM;
                                end
                            end
                        end else begin
                            r_tmr <= r_tmr + TMR_W'(1);
                        end
                    end
                    S_CSUM: begin
                        if (w_xfer) begin
                            r_tmr      <= '0;
                            r_rx_ready <= 1'b0;
                            r_hold     <= '0;
                            r_state    <= S_HOLD;
                            if (rx_data != r_csum) begin
                                r_err <= 2'b01;
                            end
                        end else begin
                            r_tmr <= r_tmr + TMR_W'(1);
                        end
                    end
                    S_HOLD: begin
                        if (r_hold == HOLD_W'(HOLD - 1)) begin
                            r_state <= S_DONE;
                        end else begin
                            r_hold <= r_hold + HOLD_W'(1);
                        end
                    end
                    S_DONE: begin
                        r_iwen  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= (r_err == 2'b00);
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state    <= S_IDLE;
                        r_rx_ready <= 1'b0;
                        r_iwen     <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Byte assembly and running checksum carry no control meaning, so they are not reset.
    always_ff @(posedge clk) begin
        if ((r_state == S_LEN) && w_xfer) begin
            r_csum <= 8'd0;
        end else if ((r_state == S_DATA) && w_xfer) begin
            r_csum <= r_csum ^ rx_data;
            r_asm  <= {r_asm[15:0], rx_data};
        end
    end

    assign rx_ready = r_rx_ready;
    assign IWEN     = r_iwen;
    assign I_Addr   = r_addr;
    assign wInst    = r_winst;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: framed loads, checksum/LEN/timeout errors, backpressure, reset.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        IWEN;
    logic [6:0]  I_Addr;
    logic [31:0] wInst;
    logic        busy;
    logic        done;
    logic [1:0]  err;

    imem_boot_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .IWEN     (IWEN),
        .I_Addr   (I_Addr),
        .wInst    (wInst),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    int          clr_gen = 0;
    int          clr_seen = 0;
    logic [31:0] tb_mem [0:127];

    // Model of the instruction memory: every IWEN-high cycle writes (I_Addr, wInst).
    always @(negedge clk) begin
        if (clr_gen != clr_seen) begin
            for (int i = 0; i < 128; i++) tb_mem[i] = 32'h0;
            clr_seen = clr_gen;
        end
        if (IWEN === 1'b1) tb_mem[I_Addr] = wInst;
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("ready_wait_expired", 32'd0, 32'd1);
        else @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] q[$], input int gapmax);
        foreach (q[i]) send_byte(q[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while (busy && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_wait_expired", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic clear_mem();
        clr_gen++;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] fr[$];
        int         dc;

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #12;
        chk("rst_iwen",   {31'd0, IWEN},     32'd0);
        chk("rst_ready",  {31'd0, rx_ready}, 32'd0);
        chk("rst_busy",   {31'd0, busy},     32'd0);
        chk("rst_done",   {31'd0, done},     32'd0);
        chk("rst_err",    {30'd0, err},      32'd0);
        chk("rst_addr",   {25'd0, I_Addr},   32'd0);
        chk("rst_winst",  wInst,             32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, rx_ready}, 32'd1);

        // Single word
        fr = '{8'hA5, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        send_frame(fr, 0);
        chk("w1_iwen_hold", {31'd0, IWEN}, 32'd1);
        chk("w1_busy_hold", {31'd0, busy}, 32'd1);
        wait_idle(50);
        chk("w1_iwen_rel", {31'd0, IWEN}, 32'd0);
        chk("w1_done",     done_cnt, 32'd1);
        chk("w1_err",      {30'd0, err}, 32'd0);
        chk("w1_mem0",     tb_mem[0], 32'h13000000);
        chk("w1_addr",     {25'd0, I_Addr}, 32'd0);
        chk("w1_winst",    wInst, 32'h13000000);

        // Three words; wInst must not move on a partial word
        clear_mem();
        fr = '{8'hA5, 8'h02, 8'h01, 8'h02};
        send_frame(fr, 0);
        chk("w3_partial_winst", wInst, 32'd0);
        chk("w3_partial_iwen",  {31'd0, IWEN}, 32'd1);
        fr = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0C};
        send_frame(fr, 0);
        wait_idle(50);
        chk("w3_mem0", tb_mem[0], 32'h01020304);
        chk("w3_mem1", tb_mem[1], 32'h05060708);
        chk("w3_mem2", tb_mem[2], 32'h090A0B0C);
        chk("w3_addr", {25'd0, I_Addr}, 32'd2);
        chk("w3_err",  {30'd0, err}, 32'd0);
        chk("w3_done", done_cnt, 32'd2);

        // Bad checksum: words still written, released without done
        clear_mem();
        fr = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
               8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h00};
        send_frame(fr, 0);
        wait_idle(50);
        chk("cs_mem0", tb_mem[0], 32'h01020304);
        chk("cs_mem2", tb_mem[2], 32'h090A0B0C);
        chk("cs_err",  {30'd0, err}, 32'd1);
        chk("cs_done", done_cnt, 32'd2);
        chk("cs_iwen", {31'd0, IWEN}, 32'd0);

        // Bad LEN aborts; next SYNC clears the error
        fr = '{8'hA5, 8'h80};
        send_frame(fr, 0);
        chk("len_iwen", {31'd0, IWEN}, 32'd0);
        chk("len_err",  {30'd0, err}, 32'd3);
        chk("len_busy", {31'd0, busy}, 32'd0);
        send_byte(8'hA5, 0);
        chk("resync_err",  {30'd0, err}, 32'd0);
        chk("resync_iwen", {31'd0, IWEN}, 32'd1);
        fr = '{8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        send_frame(fr, 0);
        wait_idle(50);
        chk("resync_mem0", tb_mem[0], 32'hDEADBEEF);
        chk("resync_done", done_cnt, 32'd3);

        // Random gaps, next frame offered during HOLD/DONE
        clear_mem();
        fr = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
               8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0C,
               8'hA5, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        send_frame(fr, 3);
        wait_idle(50);
        chk("bp_mem0", tb_mem[0], 32'h11223344);
        chk("bp_mem1", tb_mem[1], 32'h05060708);
        chk("bp_mem2", tb_mem[2], 32'h090A0B0C);
        chk("bp_done", done_cnt, 32'd5);
        chk("bp_err",  {30'd0, err}, 32'd0);

        // Full 128-word image: bytes 0..511 mod 256, checksum 00
        clear_mem();
        fr = '{8'hA5, 8'h7F};
        for (int i = 0; i < 512; i++) fr.push_back(i[7:0]);
        fr.push_back(8'h00);
        send_frame(fr, 0);
        wait_idle(50);
        chk("full_mem0",   tb_mem[0],   32'h00010203);
        chk("full_mem64",  tb_mem[64],  32'h00010203);
        chk("full_mem127", tb_mem[127], 32'hFCFDFEFF);
        chk("full_addr",   {25'd0, I_Addr}, 32'd127);
        chk("full_done",   done_cnt, 32'd6);

        // Stall inside a word until timeout
        dc = done_cnt;
        fr = '{8'hA5, 8'h00, 8'h11, 8'h22};
        send_frame(fr, 0);
        repeat (49000) @(negedge clk);
        chk("tmo_early_iwen", {31'd0, IWEN}, 32'd1);
        begin
            int n;
            n = 0;
            while (IWEN && n < 2000) begin
                @(negedge clk);
                n++;
            end
        end
        @(negedge clk);
        chk("tmo_iwen",  {31'd0, IWEN}, 32'd0);
        chk("tmo_err",   {30'd0, err}, 32'd2);
        chk("tmo_addr",  {25'd0, I_Addr}, 32'd0);
        chk("tmo_winst", wInst, 32'd0);
        chk("tmo_busy",  {31'd0, busy}, 32'd0);
        chk("tmo_done",  done_cnt, dc);

        // Asynchronous reset mid-DATA
        fr = '{8'hA5, 8'h01, 8'hAA, 8'hBB, 8'hCC};
        send_frame(fr, 0);
        chk("ar_iwen_before", {31'd0, IWEN}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_iwen",  {31'd0, IWEN}, 32'd0);
        chk("ar_ready", {31'd0, rx_ready}, 32'd0);
        chk("ar_busy",  {31'd0, busy}, 32'd0);
        chk("ar_err",   {30'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_ready_after", {31'd0, rx_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
